// File: rtl/alu_arbiter.sv
// Two requesters share one N-bit add/subtract unit, one operation in flight at a time.
// Define ALU_ARB_ROUND_ROBIN_EN for round-robin grants; otherwise requester 0 has fixed priority.
module alu_arbiter #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [1:0]   req_valid,
   output logic [1:0]   req_ready,
   input  logic [N-1:0] req0_a,
   input  logic [N-1:0] req0_b,
   input  logic [N-1:0] req1_a,
   input  logic [N-1:0] req1_b,
   input  logic [1:0]   req_op,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic         rsp_id,
   output logic [N-1:0] rsp_data,
   output logic         rsp_cout
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   state_e       state_q, state_d;
   logic [N-1:0] a_q, a_d;
   logic [N-1:0] b_q, b_d;
   logic         op_q, op_d;
   logic         id_q, id_d;
   logic         rsp_valid_q, rsp_valid_d;
   logic         rsp_id_q, rsp_id_d;
   logic         rsp_cout_q, rsp_cout_d;
   logic [N-1:0] rsp_data_q, rsp_data_d;
   logic         gnt_id_s;
   logic [1:0]   ready_s;
   logic [N:0]   result_s;

   // Subtract is a + ~b + 1 so the top bit is the "no borrow" flag (a >= b unsigned).
   function automatic logic [N:0] addsub(input logic [N-1:0] a, input logic [N-1:0] b,
                                         input logic sub);
      logic [N:0] b_ext;
      logic [N:0] cin;
      b_ext = {1'b0, (sub ? ~b : b)};
      cin   = {{N{1'b0}}, sub};
      return {1'b0, a} + b_ext + cin;
   endfunction

`ifdef ALU_ARB_ROUND_ROBIN_EN
   logic rr_q, rr_d;

   // Round-robin grant: rr_q names the requester favoured on a tie.
   always_comb begin
      gnt_id_s = 1'b0;
      rr_d     = rr_q;
      if (req_valid == 2'b11) begin
         gnt_id_s = rr_q;
      end else if (req_valid[1]) begin
         gnt_id_s = 1'b1;
      end else begin
         gnt_id_s = 1'b0;
      end
      if ((state_q == ST_IDLE) && (req_valid != 2'b00)) begin
         rr_d = ~gnt_id_s;
      end else begin
         rr_d = rr_q;
      end
   end

   // Pointer register, moves only when a grant is issued.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_q <= 1'b0;
      end else begin
         rr_q <= rr_d;
      end
   end
`else
   // Fixed-priority grant: requester 0 wins any tie.
   always_comb begin
      gnt_id_s = 1'b0;
      if (req_valid[0]) begin
         gnt_id_s = 1'b0;
      end else if (req_valid[1]) begin
         gnt_id_s = 1'b1;
      end else begin
         gnt_id_s = 1'b0;
      end
   end
`endif

   assign result_s = addsub(a_q, b_q, op_q);

   // Next-state and datapath capture for the IDLE -> EXEC -> RESP sequence.
   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      op_d        = op_q;
      id_d        = id_q;
      rsp_valid_d = rsp_valid_q;
      rsp_id_d    = rsp_id_q;
      rsp_cout_d  = rsp_cout_q;
      rsp_data_d  = rsp_data_q;
      ready_s     = 2'b00;
      case (state_q)
         ST_IDLE: begin
            if (req_valid != 2'b00) begin
               ready_s = gnt_id_s ? 2'b10 : 2'b01;
               a_d     = gnt_id_s ? req1_a : req0_a;
               b_d     = gnt_id_s ? req1_b : req0_b;
               op_d    = req_op[gnt_id_s];
               id_d    = gnt_id_s;
               state_d = ST_EXEC;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_EXEC: begin
            rsp_data_d  = result_s[N-1:0];
            rsp_cout_d  = result_s[N];
            rsp_id_d    = id_q;
            rsp_valid_d = 1'b1;
            state_d     = ST_RESP;
         end
         ST_RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end else begin
               state_d = ST_RESP;
            end
         end
         default: begin
            rsp_valid_d = 1'b0;
            state_d     = ST_IDLE;
         end
      endcase
   end

   // State, latched operands and response registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         a_q         <= {N{1'b0}};
         b_q         <= {N{1'b0}};
         op_q        <= 1'b0;
         id_q        <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= 1'b0;
         rsp_cout_q  <= 1'b0;
         rsp_data_q  <= {N{1'b0}};
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         op_q        <= op_d;
         id_q        <= id_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_cout_q  <= rsp_cout_d;
         rsp_data_q  <= rsp_data_d;
      end
   end

   // The grant is combinational, so it must be masked while reset is held.
   assign req_ready = rst_n ? ready_s : 2'b00;
   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_cout  = rsp_cout_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus a randomized run
// against a transaction-level reference model.
module tb_alu_arbiter;
   localparam int N = 4;
`ifdef ALU_ARB_ROUND_ROBIN_EN
   localparam bit RR_EN = 1'b1;
`else
   localparam bit RR_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [1:0] req_valid = 2'b00;
   logic [1:0] req_ready;
   logic [3:0] req0_a = 4'h0, req0_b = 4'h0, req1_a = 4'h0, req1_b = 4'h0;
   logic [1:0] req_op = 2'b00;
   logic       rsp_valid;
   logic       rsp_ready = 1'b0;
   logic       rsp_id;
   logic [3:0] rsp_data;
   logic       rsp_cout;

   int checks = 0;
   int failures = 0;
   int fav = 0;

   localparam logic       TID [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
   localparam logic [3:0] TA  [5] = '{4'h7, 4'h3, 4'h5, 4'hF, 4'h8};
   localparam logic [3:0] TB  [5] = '{4'h9, 4'h5, 4'h3, 4'hF, 4'h8};
   localparam logic       TS  [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
   localparam logic [3:0] TD  [5] = '{4'h0, 4'hE, 4'h2, 4'hE, 4'h0};
   localparam logic       TC  [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

   alu_arbiter #(.N(N)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
      .req_op(req_op), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_cout(rsp_cout)
   );

   always #5 clk = ~clk;

   // {cout, data} from plain integer arithmetic
   function automatic logic [4:0] ref_result(input int a, input int b, input logic sub);
      int   r;
      logic c;
      if (sub) begin
         r = (a - b) & 15;
         c = (a >= b);
      end else begin
         r = (a + b) & 15;
         c = ((a + b) > 15);
      end
      return {c, 4'(r)};
   endfunction

   function automatic int pick(input logic [1:0] v);
      if (v == 2'b11) return RR_EN ? fav : 0;
      if (v[0]) return 0;
      return 1;
   endfunction

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 1'b0;
      step; step;
      rst_n = 1'b1;
      fav = 0;
   endtask

   task automatic run_one(input logic id, input logic [3:0] a, input logic [3:0] b,
                          input logic sub, output logic [3:0] d, output logic c,
                          output logic rid, output int lat, output bit acc);
      int w;
      rsp_ready = 1'b1;
      req_op = id ? {sub, 1'b0} : {1'b0, sub};
      if (id) begin
         req1_a = a; req1_b = b; req0_a = 4'($urandom); req0_b = 4'($urandom); req_valid = 2'b10;
      end else begin
         req0_a = a; req0_b = b; req1_a = 4'($urandom); req1_b = 4'($urandom); req_valid = 2'b01;
      end
      #1;
      w = 0;
      while (req_ready !== req_valid && w < 8) begin
         step; w++;
      end
      acc = (req_ready === req_valid);
      step;
      req_valid = 2'b00;
      req0_a = 4'($urandom); req0_b = 4'($urandom); req1_a = 4'($urandom); req1_b = 4'($urandom);
      req_op = 2'($urandom);
      lat = 1;
      while (rsp_valid !== 1'b1 && lat < 8) begin
         step; lat++;
      end
      d = rsp_data; c = rsp_cout; rid = rsp_id;
      step;
   endtask

   task automatic test_reset;
      req_valid = 2'b11; rsp_ready = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      checks += 5;
      if (req_ready !== 2'b00) begin failures++; $display("FAIL reset_ready got=%b exp=00", req_ready); end
      if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", rsp_valid); end
      if (rsp_data !== 4'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", rsp_data); end
      if (rsp_cout !== 1'b0) begin failures++; $display("FAIL reset_cout got=%b exp=0", rsp_cout); end
      if (rsp_id !== 1'b0) begin failures++; $display("FAIL reset_id got=%b exp=0", rsp_id); end
      step; step;
      checks++;
      if (req_ready !== 2'b00) begin failures++; $display("FAIL reset_ready_held got=%b exp=00", req_ready); end
      req_valid = 2'b00;
      rst_n = 1'b1;
      fav = 0;
      step;
   endtask

   task automatic test_add_sub;
      logic [3:0] d;
      logic c, rid;
      int lat;
      bit acc;
      for (int i = 0; i < 5; i++) begin
         run_one(TID[i], TA[i], TB[i], TS[i], d, c, rid, lat, acc);
         checks += 6;
         if (!acc) begin failures++; $display("FAIL vec%0d_accept got=0 exp=1", i); end
         if (lat != 2) begin failures++; $display("FAIL vec%0d_latency got=%0d exp=2", i, lat); end
         if (d !== TD[i]) begin failures++; $display("FAIL vec%0d_data got=%h exp=%h", i, d, TD[i]); end
         if (c !== TC[i]) begin failures++; $display("FAIL vec%0d_cout got=%b exp=%b", i, c, TC[i]); end
         if (rid !== TID[i]) begin failures++; $display("FAIL vec%0d_id got=%b exp=%b", i, rid, TID[i]); end
         if (rsp_valid !== 1'b0) begin failures++; $display("FAIL vec%0d_valid_drop got=%b exp=0", i, rsp_valid); end
      end
   endtask

   task automatic test_arbitration;
      logic ids [4];
      int n, cyc;
      bit saw_r1;
      do_reset;
      rsp_ready = 1'b1; req_valid = 2'b11;
      req0_a = 4'h1; req0_b = 4'h1; req1_a = 4'h2; req1_b = 4'h2; req_op = 2'b00;
      n = 0; cyc = 0; saw_r1 = 1'b0;
      #1;
      while (n < 4 && cyc < 40) begin
         if (rsp_valid === 1'b1) begin ids[n] = rsp_id; n++; end
         if (req_ready[1] === 1'b1) saw_r1 = 1'b1;
         step; cyc++;
      end
      req_valid = 2'b00;
      checks += 2;
      if (n != 4) begin failures++; $display("FAIL arb_count got=%0d exp=4", n); end
      if (saw_r1 != RR_EN) begin failures++; $display("FAIL arb_ready1_seen got=%b exp=%b", saw_r1, RR_EN); end
      for (int k = 0; k < n; k++) begin
         checks++;
         if (ids[k] !== (RR_EN ? 1'(k % 2) : 1'b0)) begin
            failures++; $display("FAIL arb_id%0d got=%b exp=%b", k, ids[k], RR_EN ? 1'(k % 2) : 1'b0);
         end
      end
      step;
   endtask

   task automatic test_backpressure;
      int w;
      logic [1:0] exp_rdy;
      rsp_ready = 1'b0; req_valid = 2'b01; req0_a = 4'hB; req0_b = 4'h6; req_op = 2'b01;
      #1;
      w = 0;
      while (req_ready !== 2'b01 && w < 8) begin step; w++; end
      checks++;
      if (req_ready !== 2'b01) begin failures++; $display("FAIL bp_accept got=%b exp=01", req_ready); end
      step;
      req_valid = 2'b11;
      step;
      for (int i = 0; i < 5; i++) begin
         checks += 5;
         if (rsp_valid !== 1'b1) begin failures++; $display("FAIL bp_valid%0d got=%b exp=1", i, rsp_valid); end
         if (rsp_data !== 4'h5) begin failures++; $display("FAIL bp_data%0d got=%h exp=5", i, rsp_data); end
         if (rsp_cout !== 1'b1) begin failures++; $display("FAIL bp_cout%0d got=%b exp=1", i, rsp_cout); end
         if (rsp_id !== 1'b0) begin failures++; $display("FAIL bp_id%0d got=%b exp=0", i, rsp_id); end
         if (req_ready !== 2'b00) begin failures++; $display("FAIL bp_ready%0d got=%b exp=00", i, req_ready); end
         req0_a = 4'($urandom); req0_b = 4'($urandom);
         step;
      end
      rsp_ready = 1'b1;
      #1;
      checks++;
      if (rsp_valid !== 1'b1) begin failures++; $display("FAIL bp_hs_valid got=%b exp=1", rsp_valid); end
      step;
      exp_rdy = RR_EN ? 2'b10 : 2'b01;
      checks += 2;
      if (rsp_valid !== 1'b0) begin failures++; $display("FAIL bp_after_valid got=%b exp=0", rsp_valid); end
      if (req_ready !== exp_rdy) begin failures++; $display("FAIL bp_idle_grant got=%b exp=%b", req_ready, exp_rdy); end
      req_valid = 2'b00;
      step;
   endtask

   task automatic test_operand_hold;
      int w;
      rsp_ready = 1'b1; req_valid = 2'b01; req0_a = 4'h2; req0_b = 4'h3; req_op = 2'b00;
      #1;
      w = 0;
      while (req_ready !== 2'b01 && w < 8) begin step; w++; end
      step;
      req0_a = 4'hF; req0_b = 4'hF; req_op = 2'b11; req_valid = 2'b00;
      step;
      checks += 3;
      if (rsp_valid !== 1'b1) begin failures++; $display("FAIL hold_valid got=%b exp=1", rsp_valid); end
      if (rsp_data !== 4'h5) begin failures++; $display("FAIL hold_data got=%h exp=5", rsp_data); end
      if (rsp_cout !== 1'b0) begin failures++; $display("FAIL hold_cout got=%b exp=0", rsp_cout); end
      step;
   endtask

   task automatic test_reset_mid;
      int w;
      bit seen;
      rsp_ready = 1'b1; req_valid = 2'b10; req1_a = 4'h9; req1_b = 4'h2; req_op = 2'b10;
      #1;
      w = 0;
      while (req_ready !== 2'b10 && w < 8) begin step; w++; end
      step;
      req_valid = 2'b11;
      #1 rst_n = 1'b0;
      #1;
      checks += 5;
      if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rmid_valid got=%b exp=0", rsp_valid); end
      if (req_ready !== 2'b00) begin failures++; $display("FAIL rmid_ready got=%b exp=00", req_ready); end
      if (rsp_data !== 4'h0) begin failures++; $display("FAIL rmid_data got=%h exp=0", rsp_data); end
      if (rsp_cout !== 1'b0) begin failures++; $display("FAIL rmid_cout got=%b exp=0", rsp_cout); end
      if (rsp_id !== 1'b0) begin failures++; $display("FAIL rmid_id got=%b exp=0", rsp_id); end
      step; step;
      req_valid = 2'b00;
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (rsp_valid !== 1'b0) seen = 1'b1;
         step;
      end
      checks++;
      if (seen) begin failures++; $display("FAIL rmid_ghost_rsp got=1 exp=0"); end
      req_valid = 2'b11; req0_a = 4'h3; req0_b = 4'h4; req1_a = 4'h1; req1_b = 4'h1; req_op = 2'b00;
      #1;
      checks++;
      if (req_ready !== 2'b01) begin failures++; $display("FAIL rmid_grant got=%b exp=01", req_ready); end
      step;
      req_valid = 2'b00;
      step;
      checks += 3;
      if (rsp_valid !== 1'b1) begin failures++; $display("FAIL rmid_new_valid got=%b exp=1", rsp_valid); end
      if (rsp_id !== 1'b0) begin failures++; $display("FAIL rmid_new_id got=%b exp=0", rsp_id); end
      if (rsp_data !== 4'h7) begin failures++; $display("FAIL rmid_new_data got=%h exp=7", rsp_data); end
      step;
   endtask

   task automatic test_random;
      bit busy;
      int age, g;
      logic [1:0] exp_rdy;
      logic exp_v, ec, eid;
      logic [3:0] ed;
      logic [4:0] r;
      do_reset;
      busy = 1'b0; age = 0; ed = 4'h0; ec = 1'b0; eid = 1'b0;
      for (int i = 0; i < 400; i++) begin
         req_valid = 2'($urandom_range(0, 3));
         req0_a = 4'($urandom); req0_b = 4'($urandom);
         req1_a = 4'($urandom); req1_b = 4'($urandom);
         req_op = 2'($urandom);
         rsp_ready = ($urandom_range(0, 3) != 0);
         #1;
         if (!busy) begin
            exp_rdy = (req_valid == 2'b00) ? 2'b00 : ((pick(req_valid) == 1) ? 2'b10 : 2'b01);
            exp_v = 1'b0;
         end else begin
            exp_rdy = 2'b00;
            exp_v = (age >= 2);
         end
         checks += 2;
         if (req_ready !== exp_rdy) begin failures++; $display("FAIL rnd%0d_ready got=%b exp=%b", i, req_ready, exp_rdy); end
         if (rsp_valid !== exp_v) begin failures++; $display("FAIL rnd%0d_valid got=%b exp=%b", i, rsp_valid, exp_v); end
         if (exp_v) begin
            checks += 3;
            if (rsp_data !== ed) begin failures++; $display("FAIL rnd%0d_data got=%h exp=%h", i, rsp_data, ed); end
            if (rsp_cout !== ec) begin failures++; $display("FAIL rnd%0d_cout got=%b exp=%b", i, rsp_cout, ec); end
            if (rsp_id !== eid) begin failures++; $display("FAIL rnd%0d_id got=%b exp=%b", i, rsp_id, eid); end
         end
         if (!busy) begin
            if (req_valid != 2'b00) begin
               g = pick(req_valid);
               if (g == 1) r = ref_result(int'(req1_a), int'(req1_b), req_op[1]);
               else r = ref_result(int'(req0_a), int'(req0_b), req_op[0]);
               ec = r[4]; ed = r[3:0]; eid = (g == 1);
               if (RR_EN) fav = 1 - g;
               busy = 1'b1; age = 1;
            end
         end else if (age >= 2 && rsp_ready) begin
            busy = 1'b0;
         end else begin
            age++;
         end
         step;
      end
      req_valid = 2'b00; rsp_ready = 1'b1;
      step; step; step;
   endtask

   initial begin
      test_reset;
      test_add_sub;
      test_arbitration;
      test_backpressure;
      test_operand_hold;
      test_reset_mid;
      test_random;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
